// File: rtl/vga_fb_arbiter_if.sv
// Bundle of the framebuffer arbiter's request/response and RAM signals.
// The master side drives requests and returns RAM read data; the slave side
// is the arbiter itself.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
);
    // Scan-out read channel
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;

    // Pixel write channel
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Full-screen clear control and status
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;
    logic [15:0]       starve_cnt;

    // Single-port framebuffer RAM
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output disp_req, disp_addr, wr_valid, wr_addr, wr_data,
               clr_start, clr_color, ram_rdata,
        input  disp_valid, disp_data, wr_ready, clr_busy, clr_done,
               starve_cnt, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_data,
               clr_start, clr_color, ram_rdata,
        output disp_valid, disp_data, wr_ready, clr_busy, clr_done,
               starve_cnt, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: scan-out reads always win the single RAM port,
// a built-in sequencer clears the whole screen, and drawing writes are queued
// in a small FIFO and drained into cycles the scan-out leaves idle.
module vga_fb_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int FB_WORDS   = 76800,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_fb_arbiter_if.slave   fb_bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] FB_LIM        = ADDR_W'(FB_WORDS);
    localparam logic [ADDR_W-1:0] FB_LAST       = ADDR_W'(FB_WORDS - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Control state
    state_t            state_q;
    logic              live_q;          // low only until the first edge after reset
    logic [DATA_W-1:0] clr_color_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              clr_done_q;
    logic [15:0]       starve_q;

    // Write FIFO
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              full_q;
    logic              empty_q;

    // Scan-out read pipeline
    logic              rd1_valid_q;
    logic              rd1_hit_q;
    logic              disp_valid_q;
    logic [DATA_W-1:0] disp_data_q;

    // Arbitration results
    logic              ram_en_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic              pop_s;
    logic              clr_wr_s;
    logic              push_s;
    logic              wr_ready_s;
    logic              disp_hit_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_data_s;

    // The FIFO accepts writes only in normal operation and never when full;
    // gating with live_q keeps wr_ready low until the first edge after reset.
    assign wr_ready_s  = live_q && (state_q == ST_RUN) && !full_q;
    assign push_s      = fb_bus.wr_valid && wr_ready_s;
    assign disp_hit_s  = live_q && fb_bus.disp_req && (fb_bus.disp_addr < FB_LIM);
    assign head_addr_s = fifo_addr_q[rd_ptr_q];
    assign head_data_s = fifo_data_q[rd_ptr_q];

    // Per-cycle RAM port decision: scan-out, then clear, then FIFO head.
    always_comb begin
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_addr_s  = '0;
        ram_wdata_s = '0;
        pop_s       = 1'b0;
        clr_wr_s    = 1'b0;
        if (live_q && fb_bus.disp_req) begin
            // Out-of-range scan-out addresses still own the cycle but skip the RAM.
            if (disp_hit_s) begin
                ram_en_s   = 1'b1;
                ram_addr_s = fb_bus.disp_addr;
            end else begin
                ram_en_s   = 1'b0;
            end
        end else if (live_q && (state_q == ST_CLEAR)) begin
            ram_en_s    = 1'b1;
            ram_we_s    = 1'b1;
            ram_addr_s  = clr_cnt_q;
            ram_wdata_s = clr_color_q;
            clr_wr_s    = 1'b1;
        end else if (live_q && !empty_q) begin
            // Only RUN or DRAIN reach here; out-of-range entries are discarded.
            pop_s = 1'b1;
            if (head_addr_s < FB_LIM) begin
                ram_en_s    = 1'b1;
                ram_we_s    = 1'b1;
                ram_addr_s  = head_addr_s;
                ram_wdata_s = head_data_s;
            end else begin
                ram_en_s    = 1'b0;
            end
        end else begin
            ram_en_s = 1'b0;
        end
    end

    // Next FIFO occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Enable flag that releases the outputs on the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // Write FIFO storage, pointers and registered full/empty flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_s) begin
                fifo_addr_q[wr_ptr_q] <= fb_bus.wr_addr;
                fifo_data_q[wr_ptr_q] <= fb_bus.wr_data;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == FIFO_FULL_CNT);
            empty_q <= (count_d == CNT_W'(0));
        end
    end

    // Clear sequencer FSM: RUN -> (DRAIN) -> CLEAR -> RUN with a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            clr_color_q <= '0;
            clr_cnt_q   <= '0;
            clr_done_q  <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (live_q && fb_bus.clr_start) begin
                        clr_color_q <= fb_bus.clr_color;
                        // A write accepted this same cycle still has to drain first.
                        if (empty_q && !push_s) begin
                            state_q <= ST_CLEAR;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (empty_q) begin
                        state_q <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clr_wr_s) begin
                        if (clr_cnt_q == FB_LAST) begin
                            clr_cnt_q  <= '0;
                            clr_done_q <= 1'b1;
                            state_q    <= ST_RUN;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // Two-stage scan-out return: RAM latency plus the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_valid_q  <= 1'b0;
            rd1_hit_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            rd1_valid_q  <= live_q && fb_bus.disp_req;
            rd1_hit_q    <= disp_hit_s;
            disp_valid_q <= rd1_valid_q;
            if (rd1_valid_q) begin
                disp_data_q <= rd1_hit_q ? fb_bus.ram_rdata : '0;
            end
        end
    end

    // Saturating count of cycles where a writer is held off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 16'h0000;
        end else if (fb_bus.wr_valid && !wr_ready_s && (starve_q != 16'hFFFF)) begin
            starve_q <= starve_q + 16'h0001;
        end
    end

    assign fb_bus.ram_en     = ram_en_s;
    assign fb_bus.ram_we     = ram_we_s;
    assign fb_bus.ram_addr   = ram_addr_s;
    assign fb_bus.ram_wdata  = ram_wdata_s;
    assign fb_bus.wr_ready   = wr_ready_s;
    assign fb_bus.clr_busy   = (state_q != ST_RUN);
    assign fb_bus.clr_done   = clr_done_q;
    assign fb_bus.disp_valid = disp_valid_q;
    assign fb_bus.disp_data  = disp_data_q;
    assign fb_bus.starve_cnt = starve_q;

endmodule
